dmem_ctrl: RTL

Parametrised, handshaked data-memory controller for the core's MEM stage. It replaces the fixed 4 KB, zero-latency byte array with several additions: configurable base address and depth, programmable access latency, valid/ready request and response channels, and fault reporting to the pipeline instead of simulation-only messages. Storage is word-organised with byte enables and implements RV32I LB/LH/LW/LBU/LHU/SB/SH/SW semantics.

---
 rtl/dmem_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// Handshaked RV32I data-memory controller for the MEM stage: word-organised
// storage with byte enables, programmable latency and fault reporting.
module dmem_ctrl #(
  parameter int unsigned DEPTH_BYTES = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_funct3_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [1:0]  resp_cause_o,
  output logic [1:0]  dbg_state
);

  localparam int unsigned DEPTH_WORDS = DEPTH_BYTES / 4;
  localparam int unsigned AW          = $clog2(DEPTH_BYTES);
  localparam int unsigned WIW         = (AW > 2) ? AW - 2 : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            we_q;
  logic [AW-1:0]   off_q;
  logic [31:0]     wdata_q;
  logic [2:0]      f3_q;

  logic [31:0]     req_off;
  logic [1:0]      fault;
  logic            accept;
  logic            do_access;
  logic            acc_we;
  logic [AW-1:0]   acc_off;
  logic [31:0]     acc_wdata;
  logic [2:0]      acc_f3;
  logic [WIW-1:0]  widx;
  logic [3:0]      be;
  logic [31:0]     wd;
  logic [31:0]     rword;
  logic [7:0]      rbyte;
  logic [15:0]     rhalf;
  logic [31:0]     load_val;

  // Request channel: a request transfers on a clock edge where req_valid_i and
  // req_ready_o are both high; the response transfers where resp_valid_o and
  // resp_ready_i are both high. Neither side may retract fields mid-transfer.
  assign req_ready_o = (state == S_IDLE);
  assign accept      = req_valid_i && (state == S_IDLE);
  assign req_off     = req_addr_i - BASE_ADDR;
  assign dbg_state   = state;

  always_comb begin
    fault = 2'd0;
    if (req_we_i ? (req_funct3_i > 3'd2)
                 : !(req_funct3_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
      fault = 2'd1;
    else if ((req_funct3_i[1:0] == 2'd1 && req_addr_i[0]) ||
             (req_funct3_i[1:0] == 2'd2 && req_addr_i[1:0] != 2'd0))
      fault = 2'd2;
    else if (req_off >= DEPTH_BYTES)
      fault = 2'd3;
  end

  // The access uses live request fields on a zero-latency accept, otherwise
  // the fields latched at acceptance.
  always_comb begin
    acc_we    = we_q;
    acc_off   = off_q;
    acc_wdata = wdata_q;
    acc_f3    = f3_q;
    if (state == S_IDLE) begin
      acc_we    = req_we_i;
      acc_off   = req_off[AW-1:0];
      acc_wdata = req_wdata_i;
      acc_f3    = req_funct3_i;
    end
  end

  assign do_access = rst_n &&
                     ((accept && fault == 2'd0 && WAIT_CYCLES == 0) ||
                      (state == S_WAIT && cnt == 4'd1));
  assign widx = WIW'(acc_off >> 2);

  always_comb begin
    be = 4'b1111;
    wd = acc_wdata;
    case (acc_f3[1:0])
      2'd0: begin
        be = 4'b0001 << acc_off[1:0];
        wd = {4{acc_wdata[7:0]}};
      end
      2'd1: begin
        be = acc_off[1] ? 4'b1100 : 4'b0011;
        wd = {2{acc_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = acc_wdata;
      end
    endcase
  end

  always_comb begin
    rword = mem[widx];
    rbyte = rword[{acc_off[1:0], 3'b000} +: 8];
    rhalf = acc_off[1] ? rword[31:16] : rword[15:0];
    case (acc_f3)
      3'd0:    load_val = {{24{rbyte[7]}}, rbyte};
      3'd1:    load_val = {{16{rhalf[15]}}, rhalf};
      3'd4:    load_val = {24'd0, rbyte};
      3'd5:    load_val = {16'd0, rhalf};
      default: load_val = rword;
    endcase
  end

  // Storage is deliberately not reset; only the control path is.
  always_ff @(posedge clk) begin
    if (do_access && acc_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we_i;
      off_q   <= req_off[AW-1:0];
      wdata_q <= req_wdata_i;
      f3_q    <= req_funct3_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= 32'd0;
      resp_err_o   <= 1'b0;
      resp_cause_o <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            if (fault != 2'd0) begin
              state        <= S_RESP;
              resp_valid_o <= 1'b1;
              resp_err_o   <= 1'b1;
              resp_cause_o <= fault;
              resp_rdata_o <= 32'd0;
            end else if (WAIT_CYCLES == 0) begin
              state        <= S_RESP;
              resp_valid_o <= 1'b1;
              resp_err_o   <= 1'b0;
              resp_cause_o <= 2'd0;
              resp_rdata_o <= acc_we ? 32'd0 : load_val;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_CYCLES);
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd1) begin
            state        <= S_RESP;
            cnt          <= 4'd0;
            resp_valid_o <= 1'b1;
            resp_err_o   <= 1'b0;
            resp_cause_o <= 2'd0;
            resp_rdata_o <= acc_we ? 32'd0 : load_val;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready_i) begin
            state        <= S_IDLE;
            resp_valid_o <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
